seq_detector_param: RTL
=======================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial bit-pattern detector, next generation of the fixed two-ones FSM.
//  - Samples a 1-bit stream qualified by in_valid and compares the last PAT_LEN accepted bits against a runtime-loadable pattern.
//  - Supports overlapping or non-overlapping matching.
//  - Emits a one-cycle match pulse and keeps a saturating match count.
//  - Sits between a serial receiver front end and the control/status logic that consumes detections.
// PARAMETERS
//  PAT_LEN      4        pattern length in bits, >= 2
//  PATTERN_RST  4'b1011  pattern register value after reset (PAT_LEN bits)
//  OVERLAP      1        1: matches may share bits; 0: history restarts after each match
//  CNT_W        8        width of match_count
// PORTS
//  clock         in   1        single clock, all logic on rising edge
//  reset         in   1        synchronous, active-high; clears all state
//  in_valid      in   1        'in' is accepted this cycle when high
//  in            in   1        serial data bit
//  pattern_load  in   1        load pattern_in into pattern register this cycle
//  pattern_in    in   PAT_LEN  new pattern; bit PAT_LEN-1 = oldest bit, bit 0 = newest bit
//  count_clr     in   1        clear match_count this cycle
//  out           out  1        registered match pulse, one cycle per match
//  match_count   out  CNT_W    saturating number of matches since reset/clear
//  armed         out  1        high when PAT_LEN valid bits are held (state RUN)
// BEHAVIOUR
//  - Reset (synchronous): out=0, match_count=0, armed=0, history=0, fill=0, pattern=PATTERN_RST, state=FILL.
//  - History is a PAT_LEN-bit shift register.
//    - On an accepted bit: hist <= {hist[PAT_LEN-2:0], in}.
//    - Newest bit is at LSB; the pattern uses the same bit order.
//  - FSM states:
//    - FILL: fill < PAT_LEN. Each accepted bit increments fill. When fill reaches PAT_LEN-1 and a bit is accepted, go to RUN.
//    - RUN: the full window is valid. Stay in RUN on every accepted bit unless an OVERLAP=0 match occurs.
//  - Match condition: the accepted bit completes a window where the next hist == pattern and the window is full, i.e.
//    - (state==RUN), or
//    - (state==FILL and fill==PAT_LEN-1).
//  - Latency: out=1 in the cycle after the clock edge that accepted the final pattern bit. Otherwise out=0.
//  - A cycle with in_valid=0 holds hist, fill and state; out=0 that cycle. Gaps never break a match.
//  - On a match:
//    - OVERLAP=1: stay in RUN with the history kept.
//    - OVERLAP=0: go to FILL with fill=0 and hist=0. Only bits after the match count toward the next window.
//  - match_count increments by 1 per match and saturates at 2^CNT_W-1; out still pulses once saturated.
//  - count_clr:
//    - Sets match_count to 0.
//    - If it coincides with a match, the result is 1: clear, then count.
//  - pattern_load:
//    - Loads pattern_in, clears hist and fill, and goes to FILL. out=0 next cycle.
//    - If it coincides with in_valid, load wins and the bit is discarded. match_count is unaffected.
//  - armed = (state==RUN), registered.
//  - Reset mid-pattern discards partial history. Bits after reset start a fresh window.
// STRUCTURE
//  - Package seq_det_pkg:
//    - state enum {FILL, RUN}
//    - default-pattern and width constants shared with the bench
//  - Sub-module seq_match_counter (CNT_W):
//    - saturating up-counter with synchronous clear
//    - clear-and-increment priority exactly as above
//  - Top level holds the FSM, history shift register, fill counter (clog2(PAT_LEN+1) bits), pattern register and compare.
// TESTING
//  1. Legacy case, PAT_LEN=2, PATTERN_RST=2'b11, in_valid=1:
//     - in = 0,0,1,1,1 -> out=0,0,0,1,1 (each sampled one cycle after the bit's edge).
//     - match_count=2.
//  2. Defaults (pattern 1011, OVERLAP=1), stream 1,0,1,1,0,1,1:
//     - out pulses after bits 4 and 7.
//     - match_count=2, armed=1 from bit 4 on.
//  3. OVERLAP=0, same stream:
//     - out pulses after bit 4 only; match_count=1; armed drops to 0 after the match.
//  4. Stream 1,0,<3 cycles in_valid=0>,1,1:
//     - out=0 during the gap; one pulse after the last 1; match_count=1.
//  5. CNT_W=2 with 5 overlapping matches:
//     - match_count=3 (saturated) and out pulses 5 times.
//     - count_clr together with a 6th match -> match_count=1.
//  6. Mid-stream events:
//     - After bits 1,0,1 assert reset, then send 1 -> no pulse, match_count=0, pattern=1011.
//     - pattern_load=4'b0110 together with in_valid -> that bit is dropped; then 0,1,1,0 -> one pulse.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the serial pattern detector.
package seq_det_pkg;

  // Detector state: FILL while the window is still being populated, RUN once it is full.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear; clear and increment in the
// same cycle yields a count of one.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear has priority over the held value but not over the coincident increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern,
// optional overlapping matches, registered match pulse and saturating count.
//
// Handshake: a data bit is accepted on a rising edge when in_valid is high and
// pattern_load is low; there is no back-pressure, so every such bit is consumed.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN     = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN_RST = PAT_LEN'(DEF_PATTERN),
  parameter bit                 OVERLAP     = 1'b1,
  parameter int                 CNT_W       = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               pattern_load,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               count_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  state_t             state, state_nxt;
  logic [PAT_LEN-1:0] hist, hist_nxt;
  logic [PAT_LEN-1:0] pattern;
  logic [FILL_W-1:0]  fill, fill_nxt;

  logic [PAT_LEN-1:0] hist_shift;
  logic               accept;
  logic               window_full;
  logic               match;

  // A pattern load discards the coincident data bit.
  assign accept      = in_valid && !pattern_load;
  assign hist_shift  = {hist[PAT_LEN-2:0], in};
  assign window_full = (state == RUN) || (fill == FILL_W'(PAT_LEN - 1));
  assign match       = accept && window_full && (hist_shift == pattern);

  // Next-state, history and fill-count logic.
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    if (pattern_load) begin
      state_nxt = FILL;
      hist_nxt  = '0;
      fill_nxt  = '0;
    end else if (accept) begin
      hist_nxt = hist_shift;
      case (state)
        FILL: begin
          fill_nxt = fill + FILL_W'(1);
          if (fill == FILL_W'(PAT_LEN - 1)) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = FILL;
        end
      endcase
      // Non-overlapping mode: only bits after a match build the next window.
      if (match && !OVERLAP) begin
        state_nxt = FILL;
        hist_nxt  = '0;
        fill_nxt  = '0;
      end
    end
  end

  // State, history, pattern and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      pattern <= PATTERN_RST;
      out     <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nxt;
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      out     <= match;
      armed   <= (state_nxt == RUN);
      if (pattern_load) begin
        pattern <= pattern_in;
      end
    end
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .inc   (match),
    .count (match_count)
  );

endmodule
